// File: rtl/alu_ctrl_pkg.sv
// ALU controller shared definitions: opcodes, ALU selects, FSM encoding.
// Imported by the decoder and the controller top.
package alu_ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'h00;
    localparam logic [4:0] OP_SUB  = 5'h01;
    localparam logic [4:0] OP_MUL  = 5'h02;
    localparam logic [4:0] OP_DIV  = 5'h03;
    localparam logic [4:0] OP_AND  = 5'h04;
    localparam logic [4:0] OP_OR   = 5'h05;
    localparam logic [4:0] OP_SHL  = 5'h06;
    localparam logic [4:0] OP_SHR  = 5'h07;
    localparam logic [4:0] OP_ROL  = 5'h08;
    localparam logic [4:0] OP_ROR  = 5'h09;
    localparam logic [4:0] OP_NEG  = 5'h0A;
    localparam logic [4:0] OP_XOR  = 5'h0B;
    localparam logic [4:0] OP_NOR  = 5'h0C;
    localparam logic [4:0] OP_NAND = 5'h0D;

    localparam logic [3:0] ALU_SEL_NOP  = 4'b0000;
    localparam logic [3:0] ALU_SEL_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SEL_SUB  = 4'b0010;
    localparam logic [3:0] ALU_SEL_MUL  = 4'b0011;
    localparam logic [3:0] ALU_SEL_DIV  = 4'b0100;
    localparam logic [3:0] ALU_SEL_AND  = 4'b0101;
    localparam logic [3:0] ALU_SEL_OR   = 4'b0110;
    localparam logic [3:0] ALU_SEL_SHL  = 4'b0111;
    localparam logic [3:0] ALU_SEL_SHR  = 4'b1000;
    localparam logic [3:0] ALU_SEL_ROL  = 4'b1001;
    localparam logic [3:0] ALU_SEL_ROR  = 4'b1010;
    localparam logic [3:0] ALU_SEL_NEG  = 4'b1011;
    localparam logic [3:0] ALU_SEL_XOR  = 4'b1100;
    localparam logic [3:0] ALU_SEL_NOR  = 4'b1101;
    localparam logic [3:0] ALU_SEL_NAND = 4'b1110;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

endpackage

// File: rtl/alu_op_decode.sv
// Opcode decoder: maps a request opcode to the ALU select plus
// legality and whether the op produces a HI word.
module alu_op_decode
    import alu_ctrl_pkg::*;
(
    input  logic [4:0] i_op,
    output logic [3:0] o_sel,
    output logic       o_legal,
    output logic       o_writes_hi
);

    // Pure lookup; anything above NAND is illegal
    always_comb begin
        o_sel       = ALU_SEL_NOP;
        o_legal     = 1'b1;
        o_writes_hi = 1'b0;
        unique case (i_op)
            OP_ADD:  o_sel = ALU_SEL_ADD;
            OP_SUB:  o_sel = ALU_SEL_SUB;
            OP_MUL: begin
                o_sel       = ALU_SEL_MUL;
                o_writes_hi = 1'b1;
            end
            OP_DIV: begin
                o_sel       = ALU_SEL_DIV;
                o_writes_hi = 1'b1;
            end
            OP_AND:  o_sel = ALU_SEL_AND;
            OP_OR:   o_sel = ALU_SEL_OR;
            OP_SHL:  o_sel = ALU_SEL_SHL;
            OP_SHR:  o_sel = ALU_SEL_SHR;
            OP_ROL:  o_sel = ALU_SEL_ROL;
            OP_ROR:  o_sel = ALU_SEL_ROR;
            OP_NEG:  o_sel = ALU_SEL_NEG;
            OP_XOR:  o_sel = ALU_SEL_XOR;
            OP_NOR:  o_sel = ALU_SEL_NOR;
            OP_NAND: o_sel = ALU_SEL_NAND;
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_ctrl.sv
// ALU controller: accepts one request, issues it to a registered ALU,
// captures the result into HI/LO and holds the response until taken.
module alu_ctrl
    import alu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_sel,
    input  logic [63:0] alu_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_lo,
    output logic [31:0] rsp_hi,
    output logic        rsp_err,
    output logic [31:0] hi_reg,
    output logic [31:0] lo_reg
);

    logic [1:0]  r_state;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [3:0]  r_sel;
    logic        r_wr_hi;
    logic [31:0] r_rsp_lo;
    logic [31:0] r_rsp_hi;
    logic        r_rsp_err;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic [3:0]  w_sel;
    logic        w_legal;
    logic        w_wr_hi;
    logic        w_accept;

    alu_op_decode u_dec (
        .i_op        (req_op),
        .o_sel       (w_sel),
        .o_legal     (w_legal),
        .o_writes_hi (w_wr_hi)
    );

    assign w_accept  = req_valid && (r_state == ST_IDLE);
    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign alu_sel   = (r_state == ST_ISSUE) ? r_sel : ALU_SEL_NOP;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign rsp_lo    = r_rsp_lo;
    assign rsp_hi    = r_rsp_hi;
    assign rsp_err   = r_rsp_err;
    assign hi_reg    = r_hi;
    assign lo_reg    = r_lo;

    // Control FSM: illegal ops skip straight to the response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept)
                        r_state <= w_legal ? ST_ISSUE : ST_RESP;
                end
                ST_ISSUE:   r_state <= ST_CAPTURE;
                ST_CAPTURE: r_state <= ST_RESP;
                ST_RESP: begin
                    if (rsp_ready)
                        r_state <= ST_IDLE;
                end
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    // Operand latch, result capture and HI/LO architectural state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_sel     <= ALU_SEL_NOP;
            r_wr_hi   <= 1'b0;
            r_rsp_lo  <= '0;
            r_rsp_hi  <= '0;
            r_rsp_err <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else if (w_accept) begin
            if (w_legal) begin
                r_a       <= req_a;
                r_b       <= req_b;
                r_sel     <= w_sel;
                r_wr_hi   <= w_wr_hi;
                r_rsp_err <= 1'b0;
            end else begin
                r_rsp_err <= 1'b1;
                r_rsp_lo  <= '0;
                r_rsp_hi  <= r_hi;
            end
        end else if (r_state == ST_CAPTURE) begin
            r_rsp_err <= 1'b0;
            r_rsp_lo  <= alu_out[31:0];
            r_lo      <= alu_out[31:0];
            if (r_wr_hi) begin
                r_rsp_hi <= alu_out[63:32];
                r_hi     <= alu_out[63:32];
            end else begin
                r_rsp_hi <= r_hi;
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: registered golden ALU on the ALU port, directed
// and random requests checked against an opcode-level result model.
module tb_alu_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_sel;
    logic [63:0] alu_out = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    logic        rsp_err;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] e_lo = '0;
    logic [31:0] e_hi = '0;
    logic        e_err = 1'b0;

    alu_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_lo    (rsp_lo),
        .rsp_hi    (rsp_hi),
        .rsp_err   (rsp_err),
        .hi_reg    (hi_reg),
        .lo_reg    (lo_reg)
    );

    always #5 clk = ~clk;

    // Golden ALU keyed on select; non-MUL/DIV ops put junk on the hi word
    function automatic logic [63:0] alu_fn(input logic [3:0] sel,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] r;
        logic [5:0]  s;
        r = 32'hBAD0_0000;
        s = {1'b0, b[4:0]};
        case (sel)
            4'd3: return {32'd0, a} * {32'd0, b};
            4'd4: return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            4'd1: r = a + b;
            4'd2: r = a - b;
            4'd5: r = a & b;
            4'd6: r = a | b;
            4'd7: r = (b >= 32) ? 32'd0 : (a << b[4:0]);
            4'd8: r = (b >= 32) ? 32'd0 : (a >> b[4:0]);
            4'd9: r = (a << s) | (a >> (6'd32 - s));
            4'd10: r = (a >> s) | (a << (6'd32 - s));
            4'd11: r = ~a + 32'd1;
            4'd12: r = a ^ b;
            4'd13: r = ~(a | b);
            4'd14: r = ~(a & b);
            default: r = 32'hBAD0_0000;
        endcase
        return {r ^ 32'h5A5A_A5A5, r};
    endfunction

    always @(posedge clk) alu_out <= alu_fn(alu_sel, alu_a, alu_b);

    // Opcode-level expectation: {legal, writes_hi, hi, lo}
    function automatic logic [65:0] ref_op(input logic [4:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        leg;
        logic        wh;
        hi = 0; lo = 0; leg = 1'b1; wh = 1'b0; p = 0;
        case (op)
            5'd0: lo = a + b;
            5'd1: lo = a - b;
            5'd2: begin
                p = {32'd0, a} * {32'd0, b};
                hi = p[63:32]; lo = p[31:0]; wh = 1'b1;
            end
            5'd3: begin
                wh = 1'b1;
                if (b == 0) begin hi = a; lo = '1; end
                else begin lo = a / b; hi = a % b; end
            end
            5'd4: lo = a & b;
            5'd5: lo = a | b;
            5'd6: lo = (b < 32) ? a << b : 32'd0;
            5'd7: lo = (b < 32) ? a >> b : 32'd0;
            5'd8: begin p = {a, a} << (b % 32); lo = p[63:32]; end
            5'd9: begin p = {a, a} >> (b % 32); lo = p[31:0]; end
            5'd10: lo = 32'd0 - a;
            5'd11: lo = a ^ b;
            5'd12: lo = ~(a | b);
            5'd13: lo = ~(a & b);
            default: leg = 1'b0;
        endcase
        return {leg, wh, hi, lo};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_err"}, rsp_err, 0);
        chk({tag, "_rsp_lo"}, rsp_lo, 0);
        chk({tag, "_rsp_hi"}, rsp_hi, 0);
        chk({tag, "_hi_reg"}, hi_reg, 0);
        chk({tag, "_lo_reg"}, lo_reg, 0);
        chk({tag, "_alu_a"}, alu_a, 0);
        chk({tag, "_alu_b"}, alu_b, 0);
        chk({tag, "_alu_sel"}, alu_sel, 0);
    endtask

    // Present a request and complete its handshake on the next edge
    task automatic send(input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b);
        int k;
        k = 0;
        while (req_ready !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        chk("send_req_ready", req_ready, 1);
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        step();
        req_valid = 1'b0;
    endtask

    // Walk the post-handshake cycles up to the first response cycle
    task automatic flow(input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b);
        logic [65:0] r;
        r = ref_op(op, a, b);
        if (!r[65]) begin
            chk("ill_rsp_valid", rsp_valid, 1);
            chk("ill_rsp_err", rsp_err, 1);
            chk("ill_rsp_lo", rsp_lo, 0);
            chk("ill_rsp_hi", rsp_hi, m_hi);
            chk("ill_alu_sel", alu_sel, 0);
            chk("ill_hi_reg", hi_reg, m_hi);
            chk("ill_lo_reg", lo_reg, m_lo);
            chk("ill_req_ready", req_ready, 0);
            e_lo = 0; e_hi = m_hi; e_err = 1'b1;
        end else begin
            chk("iss_alu_sel", alu_sel, op + 64'd1);
            chk("iss_alu_a", alu_a, a);
            chk("iss_alu_b", alu_b, b);
            chk("iss_rsp_valid", rsp_valid, 0);
            chk("iss_req_ready", req_ready, 0);
            step();
            chk("cap_alu_sel", alu_sel, 0);
            chk("cap_alu_a", alu_a, a);
            chk("cap_rsp_valid", rsp_valid, 0);
            step();
            if (r[64]) m_hi = r[63:32];
            m_lo = r[31:0];
            e_lo = m_lo; e_hi = m_hi; e_err = 1'b0;
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_lo", rsp_lo, e_lo);
            chk("rsp_hi", rsp_hi, e_hi);
            chk("rsp_err", rsp_err, 0);
            chk("lo_reg", lo_reg, m_lo);
            chk("hi_reg", hi_reg, m_hi);
            chk("rsp_alu_sel", alu_sel, 0);
        end
    endtask

    // Hold the response for some cycles, then take it
    task automatic drain(input int hold);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_lo", rsp_lo, e_lo);
            chk("hold_rsp_hi", rsp_hi, e_hi);
            chk("hold_rsp_err", rsp_err, e_err);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_alu_sel", alu_sel, 0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_req_ready", req_ready, 1);
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        #2;
        check_reset_vals("rst");
        #10;
        reset = 1'b0;

        send(5'h00, 32'd5, 32'd7);
        flow(5'h00, 32'd5, 32'd7);
        chk("add_lo_reg", lo_reg, 12);
        drain(0);

        send(5'h02, 32'h0001_0000, 32'h0001_0000);
        flow(5'h02, 32'h0001_0000, 32'h0001_0000);
        chk("mul_hi_reg", hi_reg, 1);
        chk("mul_lo_reg", lo_reg, 0);
        drain(1);

        send(5'h05, 32'hF0, 32'h0F);
        flow(5'h05, 32'hF0, 32'h0F);
        chk("or_lo_reg", lo_reg, 32'hFF);
        chk("or_hi_reg", hi_reg, 1);
        req_valid = 1'b1;
        req_op = 5'h00;
        req_a = 32'd3;
        req_b = 32'd4;
        drain(5);
        step();
        req_valid = 1'b0;
        flow(5'h00, 32'd3, 32'd4);
        drain(0);

        send(5'h1F, 32'h1234_5678, 32'h9ABC_DEF0);
        flow(5'h1F, 32'h1234_5678, 32'h9ABC_DEF0);
        drain(2);

        send(5'h03, 32'd100, 32'd7);
        chk("div_iss_sel", alu_sel, 4);
        step();
        #1;
        reset = 1'b1;
        #1;
        check_reset_vals("rst_cap");
        step();
        chk("rst_hold_rsp_valid", rsp_valid, 0);
        chk("rst_hold_req_ready", req_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        m_hi = 0;
        m_lo = 0;
        send(5'h00, 32'd1, 32'd1);
        flow(5'h00, 32'd1, 32'd1);
        chk("post_rst_lo_reg", lo_reg, 2);
        drain(0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0)
                op = 5'($urandom_range(14, 31));
            else
                op = 5'($urandom_range(0, 13));
            a = $urandom;
            b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40))
                                            : $urandom;
            send(op, a, b);
            flow(op, a, b);
            drain(int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
